// File: rtl/ycc_stream_sched_if.sv
// ycc_stream_sched_if: Y/Cb/Cr word inputs and merged JPEG output bundle.
// slave = scheduler side, master = pipelines/downstream side.
interface ycc_stream_sched_if #(
  parameter int MCU_CNT_W = 16
);
  logic [31:0]          y_data;
  logic                 y_valid;
  logic                 y_last;
  logic [31:0]          cb_data;
  logic                 cb_valid;
  logic                 cb_last;
  logic [31:0]          cr_data;
  logic                 cr_valid;
  logic                 cr_last;
  logic                 out_ready;
  logic [31:0]          JPEG_bitstream;
  logic                 data_ready;
  logic [1:0]           comp_id;
  logic                 mcu_last;
  logic [MCU_CNT_W-1:0] mcu_count;
  logic [2:0]           overflow;

  modport slave (
    input  y_data, y_valid, y_last,
    input  cb_data, cb_valid, cb_last,
    input  cr_data, cr_valid, cr_last,
    input  out_ready,
    output JPEG_bitstream, data_ready,
    output comp_id, mcu_last,
    output mcu_count, overflow
  );

  modport master (
    output y_data, y_valid, y_last,
    output cb_data, cb_valid, cb_last,
    output cr_data, cr_valid, cr_last,
    output out_ready,
    input  JPEG_bitstream, data_ready,
    input  comp_id, mcu_last,
    input  mcu_count, overflow
  );
endinterface

// File: rtl/ycc_stream_sched.sv
// ycc_stream_sched: buffers Y/Cb/Cr Huffman words in per-component FIFOs
// and drains them block by block in MCU order Y, Cb, Cr onto one output.
// Ports: clk, rst (async, active-high), bus (ycc_stream_sched_if.slave).
module ycc_stream_sched #(
  parameter int FIFO_DEPTH = 16,
  parameter int MCU_CNT_W  = 16
) (
  input logic               clk,
  input logic               rst,
  ycc_stream_sched_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] SERVE_Y  = 2'd0;
  localparam logic [1:0] SERVE_CB = 2'd1;
  localparam logic [1:0] SERVE_CR = 2'd2;

  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [MCU_CNT_W-1:0] CNT_ONE = 1;

  logic [1:0]  state;
  logic [1:0]  state_nxt;

  logic [32:0] mem [3][FIFO_DEPTH];
  logic [AW:0] wp  [3];
  logic [AW:0] rp  [3];
  logic [32:0] din [3];

  logic [2:0]  valid;
  logic [2:0]  full;
  logic [2:0]  empty;
  logic [2:0]  pop;
  logic [2:0]  push;
  logic [2:0]  drop;
  logic [2:0]  ovf;

  logic [32:0] head;
  logic        cur_empty;
  logic        pop_any;
  logic        adv;

  logic [31:0]          out_data;
  logic                 out_vld;
  logic [1:0]           out_cid;
  logic                 out_ml;
  logic [MCU_CNT_W-1:0] cnt;

  assign valid = {bus.cr_valid, bus.cb_valid, bus.y_valid};

  always_comb begin
    din[0] = {bus.y_last, bus.y_data};
    din[1] = {bus.cb_last, bus.cb_data};
    din[2] = {bus.cr_last, bus.cr_data};
  end

  always_comb begin
    empty = '0;
    full  = '0;
    for (int n = 0; n < 3; n++) begin
      empty[n] = (wp[n] == rp[n]);
      full[n]  = (wp[n][AW] != rp[n][AW]) &&
                 (wp[n][AW-1:0] == rp[n][AW-1:0]);
    end
  end

  always_comb begin
    head      = '0;
    cur_empty = 1'b1;
    unique case (state)
      SERVE_Y: begin
        head      = mem[0][rp[0][AW-1:0]];
        cur_empty = empty[0];
      end
      SERVE_CB: begin
        head      = mem[1][rp[1][AW-1:0]];
        cur_empty = empty[1];
      end
      SERVE_CR: begin
        head      = mem[2][rp[2][AW-1:0]];
        cur_empty = empty[2];
      end
      default: ;
    endcase
  end

  // Output register is free, or is being emptied this cycle.
  assign pop_any = !cur_empty && (!out_vld || bus.out_ready);
  assign adv     = pop_any && head[32];

  assign pop[0] = pop_any && (state == SERVE_Y);
  assign pop[1] = pop_any && (state == SERVE_CB);
  assign pop[2] = pop_any && (state == SERVE_CR);

  // A full FIFO still takes a word when it frees a slot this cycle.
  assign push = valid & (~full | pop);
  assign drop = valid & full & ~pop;

  always_comb begin
    state_nxt = state;
    unique case (state)
      SERVE_Y:  if (adv) state_nxt = SERVE_CB;
      SERVE_CB: if (adv) state_nxt = SERVE_CR;
      SERVE_CR: if (adv) state_nxt = SERVE_Y;
      default:  state_nxt = SERVE_Y;
    endcase
  end

  always_ff @(posedge clk) begin
    for (int n = 0; n < 3; n++) begin
      if (push[n]) mem[n][wp[n][AW-1:0]] <= din[n];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < 3; n++) begin
        wp[n] <= '0;
        rp[n] <= '0;
      end
      ovf <= '0;
    end else begin
      for (int n = 0; n < 3; n++) begin
        if (push[n]) wp[n] <= wp[n] + PTR_ONE;
        if (pop[n])  rp[n] <= rp[n] + PTR_ONE;
      end
      ovf <= ovf | drop;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SERVE_Y;
      out_data <= '0;
      out_vld  <= 1'b0;
      out_cid  <= '0;
      out_ml   <= 1'b0;
      cnt      <= '0;
    end else begin
      state <= state_nxt;
      if (out_vld && bus.out_ready && out_ml) begin
        cnt <= cnt + CNT_ONE;
      end
      if (pop_any) begin
        out_data <= head[31:0];
        out_vld  <= 1'b1;
        out_cid  <= state;
        out_ml   <= (state == SERVE_CR) && head[32];
      end else if (bus.out_ready) begin
        out_vld <= 1'b0;
      end
    end
  end

  assign bus.JPEG_bitstream = out_data;
  assign bus.data_ready     = out_vld;
  assign bus.comp_id        = out_cid;
  assign bus.mcu_last       = out_ml;
  assign bus.mcu_count      = cnt;
  assign bus.overflow       = ovf;
endmodule

// File: tb/tb_ycc_stream_sched.sv
// tb_ycc_stream_sched: directed scenarios for the Y/Cb/Cr stream scheduler.
// Transfers are logged by a monitor; each task checks its own results.
module tb_ycc_stream_sched;
  localparam int MW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  ycc_stream_sched_if #(.MCU_CNT_W(MW)) bus ();

  ycc_stream_sched #(
    .FIFO_DEPTH(16),
    .MCU_CNT_W (MW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [31:0] q_d[$];
  logic [1:0]  q_c[$];
  logic        q_l[$];

  always @(posedge clk) begin
    if (!rst && bus.data_ready && bus.out_ready) begin
      q_d.push_back(bus.JPEG_bitstream);
      q_c.push_back(bus.comp_id);
      q_l.push_back(bus.mcu_last);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    bus.y_valid  = 1'b0;
    bus.y_last   = 1'b0;
    bus.y_data   = '0;
    bus.cb_valid = 1'b0;
    bus.cb_last  = 1'b0;
    bus.cb_data  = '0;
    bus.cr_valid = 1'b0;
    bus.cr_last  = 1'b0;
    bus.cr_data  = '0;
  endtask

  task automatic q_clr();
    q_d.delete();
    q_c.delete();
    q_l.delete();
  endtask

  task automatic apply_reset();
    clr_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] ed [4];
    logic [1:0]  ec [4];
    logic        el [4];
    logic [31:0] gd;
    logic [1:0]  gc;
    logic        gl;
    ed = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004};
    ec = '{2'd0, 2'd0, 2'd1, 2'd2};
    el = '{1'b0, 1'b0, 1'b0, 1'b1};
    clr_in();
    bus.out_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (bus.JPEG_bitstream !== 32'h0 || bus.data_ready !== 1'b0 ||
        bus.comp_id !== 2'd0 || bus.mcu_last !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_out got %h/%b/%0d/%b want 0/0/0/0",
               bus.JPEG_bitstream, bus.data_ready,
               bus.comp_id, bus.mcu_last);
    end
    n_cmp++;
    if (bus.mcu_count !== '0 || bus.overflow !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_cnt got %0d/%b want 0/000",
               bus.mcu_count, bus.overflow);
    end
    rst = 1'b0;
    bus.out_ready = 1'b1;
    q_clr();
    bus.y_valid = 1'b1;
    bus.y_data  = ed[0];
    tick();
    bus.y_data  = ed[1];
    bus.y_last  = 1'b1;
    tick();
    clr_in();
    bus.cb_valid = 1'b1;
    bus.cb_data  = ed[2];
    bus.cb_last  = 1'b1;
    tick();
    clr_in();
    bus.cr_valid = 1'b1;
    bus.cr_data  = ed[3];
    bus.cr_last  = 1'b1;
    tick();
    clr_in();
    repeat (6) tick();
    n_cmp++;
    if (q_d.size() != 4) begin
      n_bad++;
      $display("FAIL reset_nwords got %0d want 4", q_d.size());
    end
    for (int i = 0; i < 4; i++) begin
      gd = (i < q_d.size()) ? q_d[i] : 32'hx;
      gc = (i < q_c.size()) ? q_c[i] : 2'bx;
      gl = (i < q_l.size()) ? q_l[i] : 1'bx;
      n_cmp++;
      if (gd !== ed[i] || gc !== ec[i] || gl !== el[i]) begin
        n_bad++;
        $display("FAIL reset_word%0d got %h/%0d/%b want %h/%0d/%b",
                 i, gd, gc, gl, ed[i], ec[i], el[i]);
      end
    end
    n_cmp++;
    if (bus.mcu_count !== 8'd1) begin
      n_bad++;
      $display("FAIL reset_mcu got %0d want 1", bus.mcu_count);
    end
  endtask

  task automatic test_ordering();
    logic [31:0] ed [3];
    logic [1:0]  ec [3];
    logic [31:0] gd;
    logic [1:0]  gc;
    int first;
    ed = '{32'h33, 32'h22, 32'h11};
    ec = '{2'd0, 2'd1, 2'd2};
    first = 0;
    q_clr();
    bus.out_ready = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      clr_in();
      if (c == 1) begin
        bus.cr_valid = 1'b1;
        bus.cr_data  = 32'h11;
        bus.cr_last  = 1'b1;
      end
      if (c == 2) begin
        bus.cb_valid = 1'b1;
        bus.cb_data  = 32'h22;
        bus.cb_last  = 1'b1;
      end
      if (c == 3) begin
        bus.y_valid = 1'b1;
        bus.y_data  = 32'h33;
        bus.y_last  = 1'b1;
      end
      if (first == 0 && bus.data_ready === 1'b1) first = c;
      tick();
    end
    clr_in();
    n_cmp++;
    if (first != 5) begin
      n_bad++;
      $display("FAIL order_latency got cycle %0d want 5", first);
    end
    n_cmp++;
    if (q_d.size() != 3) begin
      n_bad++;
      $display("FAIL order_nwords got %0d want 3", q_d.size());
    end
    for (int i = 0; i < 3; i++) begin
      gd = (i < q_d.size()) ? q_d[i] : 32'hx;
      gc = (i < q_c.size()) ? q_c[i] : 2'bx;
      n_cmp++;
      if (gd !== ed[i] || gc !== ec[i]) begin
        n_bad++;
        $display("FAIL order_word%0d got %h/%0d want %h/%0d",
                 i, gd, gc, ed[i], ec[i]);
      end
    end
    n_cmp++;
    if (bus.mcu_count !== 8'd2) begin
      n_bad++;
      $display("FAIL order_mcu got %0d want 2", bus.mcu_count);
    end
  endtask

  task automatic test_backpressure();
    q_clr();
    bus.out_ready = 1'b0;
    clr_in();
    bus.y_valid = 1'b1;
    bus.y_data  = 32'hDEAD_BEEF;
    bus.y_last  = 1'b1;
    tick();
    clr_in();
    tick();
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (bus.data_ready !== 1'b1 || bus.JPEG_bitstream !== 32'hDEAD_BEEF ||
          bus.comp_id !== 2'd0) begin
        n_bad++;
        $display("FAIL bp_hold%0d got %b/%h/%0d want 1/deadbeef/0",
                 i, bus.data_ready, bus.JPEG_bitstream, bus.comp_id);
      end
      tick();
    end
    n_cmp++;
    if (q_d.size() != 0) begin
      n_bad++;
      $display("FAIL bp_early got %0d transfers want 0", q_d.size());
    end
    bus.out_ready = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (q_d.size() != 1 || bus.data_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_release got %0d xfers dr=%b want 1 xfers dr=0",
               q_d.size(), bus.data_ready);
    end
    n_cmp++;
    if (q_d.size() > 0 && q_d[0] !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL bp_word got %h want deadbeef", q_d[0]);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] gd;
    logic [1:0]  gc;
    logic        gl;
    logic [31:0] wd;
    logic [1:0]  wc;
    logic        wl;
    bus.out_ready = 1'b1;
    clr_in();
    bus.cb_valid = 1'b1;
    bus.cb_data  = 32'h44;
    bus.cb_last  = 1'b1;
    tick();
    clr_in();
    tick();
    tick();
    bus.out_ready = 1'b0;
    bus.cr_valid = 1'b1;
    bus.cr_data  = 32'h55;
    bus.cr_last  = 1'b1;
    tick();
    clr_in();
    tick();
    tick();
    n_cmp++;
    if (bus.data_ready !== 1'b1 || bus.JPEG_bitstream !== 32'h55 ||
        bus.mcu_last !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_stall got %b/%h/%b want 1/00000055/1",
               bus.data_ready, bus.JPEG_bitstream, bus.mcu_last);
    end
    q_clr();
    for (int i = 1; i <= 17; i++) begin
      bus.y_valid = 1'b1;
      bus.y_data  = 32'h100 + i;
      bus.y_last  = (i >= 16);
      tick();
    end
    clr_in();
    tick();
    n_cmp++;
    if (bus.overflow !== 3'b001) begin
      n_bad++;
      $display("FAIL ovf_flag got %b want 001", bus.overflow);
    end
    bus.out_ready = 1'b1;
    repeat (25) tick();
    n_cmp++;
    if (q_d.size() != 17) begin
      n_bad++;
      $display("FAIL ovf_nwords got %0d want 17", q_d.size());
    end
    for (int i = 0; i < 17; i++) begin
      gd = (i < q_d.size()) ? q_d[i] : 32'hx;
      gc = (i < q_c.size()) ? q_c[i] : 2'bx;
      gl = (i < q_l.size()) ? q_l[i] : 1'bx;
      wd = (i == 0) ? 32'h55 : 32'h100 + i;
      wc = (i == 0) ? 2'd2 : 2'd0;
      wl = (i == 0);
      n_cmp++;
      if (gd !== wd || gc !== wc || gl !== wl) begin
        n_bad++;
        $display("FAIL ovf_word%0d got %h/%0d/%b want %h/%0d/%b",
                 i, gd, gc, gl, wd, wc, wl);
      end
    end
    n_cmp++;
    if (bus.mcu_count !== 8'd3 || bus.overflow !== 3'b001) begin
      n_bad++;
      $display("FAIL ovf_after got %0d/%b want 3/001",
               bus.mcu_count, bus.overflow);
    end
  endtask

  task automatic test_full_pushpop();
    logic [31:0] gd;
    apply_reset();
    bus.out_ready = 1'b0;
    q_clr();
    for (int i = 1; i <= 17; i++) begin
      bus.y_valid = 1'b1;
      bus.y_data  = 32'h200 + i;
      bus.y_last  = 1'b0;
      tick();
    end
    clr_in();
    n_cmp++;
    if (bus.overflow !== 3'b000 || bus.JPEG_bitstream !== 32'h201) begin
      n_bad++;
      $display("FAIL full_fill got %b/%h want 000/00000201",
               bus.overflow, bus.JPEG_bitstream);
    end
    bus.out_ready = 1'b1;
    bus.y_valid   = 1'b1;
    bus.y_data    = 32'h212;
    bus.y_last    = 1'b1;
    tick();
    clr_in();
    n_cmp++;
    if (bus.overflow !== 3'b000) begin
      n_bad++;
      $display("FAIL full_pushpop_ovf got %b want 000", bus.overflow);
    end
    repeat (25) tick();
    n_cmp++;
    if (q_d.size() != 18) begin
      n_bad++;
      $display("FAIL full_nwords got %0d want 18", q_d.size());
    end
    for (int i = 0; i < 18; i++) begin
      gd = (i < q_d.size()) ? q_d[i] : 32'hx;
      n_cmp++;
      if (gd !== 32'h201 + i) begin
        n_bad++;
        $display("FAIL full_word%0d got %h want %h", i, gd, 32'h201 + i);
      end
    end
  endtask

  task automatic test_reset_mid_wrap();
    logic [31:0] gd;
    logic [1:0]  gc;
    apply_reset();
    bus.out_ready = 1'b1;
    bus.y_valid = 1'b1;
    bus.y_data  = 32'h60;
    bus.y_last  = 1'b1;
    tick();
    clr_in();
    tick();
    tick();
    bus.out_ready = 1'b0;
    bus.cb_valid = 1'b1;
    bus.cb_data  = 32'h61;
    tick();
    bus.cb_data  = 32'h62;
    tick();
    clr_in();
    tick();
    n_cmp++;
    if (bus.data_ready !== 1'b1 || bus.comp_id !== 2'd1 ||
        bus.JPEG_bitstream !== 32'h61) begin
      n_bad++;
      $display("FAIL mid_setup got %b/%0d/%h want 1/1/00000061",
               bus.data_ready, bus.comp_id, bus.JPEG_bitstream);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.data_ready !== 1'b0 || bus.comp_id !== 2'd0 ||
        bus.JPEG_bitstream !== 32'h0 || bus.mcu_count !== '0) begin
      n_bad++;
      $display("FAIL mid_async got %b/%0d/%h/%0d want 0/0/0/0",
               bus.data_ready, bus.comp_id, bus.JPEG_bitstream,
               bus.mcu_count);
    end
    tick();
    rst = 1'b0;
    q_clr();
    bus.out_ready = 1'b1;
    bus.cb_valid = 1'b1;
    bus.cb_data  = 32'h71;
    bus.cb_last  = 1'b1;
    bus.y_valid  = 1'b1;
    bus.y_data   = 32'h72;
    bus.y_last   = 1'b1;
    tick();
    clr_in();
    repeat (5) tick();
    n_cmp++;
    if (q_d.size() != 2) begin
      n_bad++;
      $display("FAIL mid_nwords got %0d want 2", q_d.size());
    end
    for (int i = 0; i < 2; i++) begin
      gd = (i < q_d.size()) ? q_d[i] : 32'hx;
      gc = (i < q_c.size()) ? q_c[i] : 2'bx;
      n_cmp++;
      if (gd !== ((i == 0) ? 32'h72 : 32'h71) || gc !== i[1:0]) begin
        n_bad++;
        $display("FAIL mid_word%0d got %h/%0d want %h/%0d", i, gd, gc,
                 (i == 0) ? 32'h72 : 32'h71, i);
      end
    end
    bus.cr_valid = 1'b1;
    bus.cr_data  = 32'h73;
    bus.cr_last  = 1'b1;
    tick();
    clr_in();
    repeat (4) tick();
    n_cmp++;
    if (bus.mcu_count !== 8'd1) begin
      n_bad++;
      $display("FAIL wrap_first got %0d want 1", bus.mcu_count);
    end
    for (int m = 0; m < 254; m++) begin
      bus.y_valid  = 1'b1;
      bus.y_last   = 1'b1;
      bus.y_data   = m;
      bus.cb_valid = 1'b1;
      bus.cb_last  = 1'b1;
      bus.cb_data  = m;
      bus.cr_valid = 1'b1;
      bus.cr_last  = 1'b1;
      bus.cr_data  = m;
      tick();
      clr_in();
      tick();
      tick();
    end
    repeat (8) tick();
    n_cmp++;
    if (bus.mcu_count !== 8'd255 || bus.overflow !== 3'b000) begin
      n_bad++;
      $display("FAIL wrap_max got %0d/%b want 255/000",
               bus.mcu_count, bus.overflow);
    end
    bus.y_valid  = 1'b1;
    bus.y_last   = 1'b1;
    bus.cb_valid = 1'b1;
    bus.cb_last  = 1'b1;
    bus.cr_valid = 1'b1;
    bus.cr_last  = 1'b1;
    tick();
    clr_in();
    repeat (8) tick();
    n_cmp++;
    if (bus.mcu_count !== 8'd0) begin
      n_bad++;
      $display("FAIL wrap_zero got %0d want 0", bus.mcu_count);
    end
  endtask

  initial begin
    clr_in();
    bus.out_ready = 1'b0;
    test_reset();
    test_ordering();
    test_backpressure();
    test_overflow();
    test_full_pushpop();
    test_reset_mid_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
